// File: rtl/node_pkg.sv
// Shared definitions for the neuron node family: FSM state encoding and
// FP32 constants.
package node_pkg;

   localparam int unsigned FP_W = 32;

   localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
   localparam logic [FP_W-1:0] FP_ONE  = 32'h3F80_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_OUT   = 2'd2
   } node_state_t;

endpackage

// File: rtl/float_adder.sv
// FP32 adder, combinational. Round-to-nearest-even, subnormals flushed to
// zero. Out_test/shift/c_out expose pre-normalisation internals.
module float_adder (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Out,
   output logic [31:0] Out_test,
   output logic [7:0]  shift,
   output logic        c_out
);

   logic [31:0] w_big, w_sml;
   logic [7:0]  w_eb, w_es, w_d;
   logic [23:0] w_mb, w_ms;
   logic [50:0] w_bx, w_sx, w_r, w_n;
   logic [22:0] w_mant;
   logic        w_guard, w_sticky, w_up, w_carry;
   int          w_p, w_e;

   // Align the smaller operand (26 guard bits plus a collapsed sticky bit),
   // add/subtract, normalise to the leading one, round.
   always_comb begin
      if (A[30:0] >= B[30:0]) begin
         w_big = A;
         w_sml = B;
      end else begin
         w_big = B;
         w_sml = A;
      end
      w_eb = w_big[30:23];
      w_es = w_sml[30:23];
      w_mb = (w_eb == 8'h00) ? 24'd0 : {1'b1, w_big[22:0]};
      w_ms = (w_es == 8'h00) ? 24'd0 : {1'b1, w_sml[22:0]};
      w_d  = w_eb - w_es;
      w_bx = {1'b0, w_mb, 26'd0};
      if (w_d > 8'd26)
         w_sx = (w_ms != 24'd0) ? 51'd1 : 51'd0;
      else
         w_sx = {1'b0, w_ms, 26'd0} >> w_d;
      if (w_big[31] == w_sml[31])
         w_r = w_bx + w_sx;
      else
         w_r = w_bx - w_sx;

      w_p = 0;
      for (int unsigned i = 0; i < 51; i++)
         if (w_r[i]) w_p = int'(i);
      w_n      = w_r << (50 - w_p);
      w_mant   = w_n[49:27];
      w_guard  = w_n[26];
      w_sticky = |w_n[25:0];
      w_up     = w_guard & (w_sticky | w_mant[0]);
      {w_carry, w_mant} = {1'b0, w_mant} + {23'd0, w_up};
      w_e = int'(w_eb) + w_p - 49 + (w_carry ? 1 : 0);

      shift    = 8'(50 - w_p);
      c_out    = w_r[50];
      Out_test = {w_big[31], w_eb, w_r[49:27]};

      if (w_eb == 8'hFF) begin
         if (w_big[22:0] != 23'd0 || (w_es == 8'hFF && w_big[31] != w_sml[31]))
            Out = 32'h7FC0_0000;
         else
            Out = w_big;
      end else if (w_r == 51'd0)
         Out = {w_big[31] & w_sml[31], 31'd0};
      else if (w_e >= 255)
         Out = {w_big[31], 8'hFF, 23'd0};
      else if (w_e <= 0)
         Out = {w_big[31], 31'd0};
      else
         Out = {w_big[31], w_e[7:0], w_mant};
   end

endmodule

// File: rtl/float_mult.sv
// FP32 multiplier, combinational. Round-to-nearest-even, subnormals are
// flushed to zero, NaN/Inf handled.
module float_mult (
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] Out
);

   logic [47:0] w_prod;
   logic [22:0] w_mant;
   logic        w_guard, w_sticky, w_up, w_carry, w_sgn;
   logic        w_a_z, w_b_z, w_a_s, w_b_s;
   int          w_e;

   // Mantissa product, normalise by one bit, round, then special cases.
   always_comb begin
      w_sgn = A[31] ^ B[31];
      w_a_z = (A[30:23] == 8'h00);
      w_b_z = (B[30:23] == 8'h00);
      w_a_s = (A[30:23] == 8'hFF);
      w_b_s = (B[30:23] == 8'hFF);
      w_prod = {24'd0, 1'b1, A[22:0]} * {24'd0, 1'b1, B[22:0]};
      if (w_prod[47]) begin
         w_mant   = w_prod[46:24];
         w_guard  = w_prod[23];
         w_sticky = |w_prod[22:0];
         w_e      = int'(A[30:23]) + int'(B[30:23]) - 126;
      end else begin
         w_mant   = w_prod[45:23];
         w_guard  = w_prod[22];
         w_sticky = |w_prod[21:0];
         w_e      = int'(A[30:23]) + int'(B[30:23]) - 127;
      end
      w_up = w_guard & (w_sticky | w_mant[0]);
      {w_carry, w_mant} = {1'b0, w_mant} + {23'd0, w_up};
      if (w_carry) w_e = w_e + 1;

      if ((w_a_s && A[22:0] != 23'd0) || (w_b_s && B[22:0] != 23'd0) ||
          (w_a_s && w_b_z) || (w_b_s && w_a_z))
         Out = 32'h7FC0_0000;
      else if (w_a_s || w_b_s)
         Out = {w_sgn, 8'hFF, 23'd0};
      else if (w_a_z || w_b_z)
         Out = {w_sgn, 31'd0};
      else if (w_e >= 255)
         Out = {w_sgn, 8'hFF, 23'd0};
      else if (w_e <= 0)
         Out = {w_sgn, 31'd0};
      else
         Out = {w_sgn, w_e[7:0], w_mant};
   end

endmodule

// File: rtl/node_weight_rf.sv
// (N_INPUTS+1) x 32 weight/bias register file. Entry N_INPUTS is the bias.
// One write port, weight read through a registered index, bias read direct.
module node_weight_rf
   import node_pkg::*;
#(
   parameter int unsigned N_INPUTS = 15,
   parameter int unsigned AW       = $clog2(N_INPUTS + 1)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [FP_W-1:0] i_wdata,
   input  logic [AW-1:0]   i_ridx,
   output logic [FP_W-1:0] o_weight,
   output logic [FP_W-1:0] o_bias
);

   logic [FP_W-1:0] r_mem [0:N_INPUTS];

   // Clear on reset; addresses above N_INPUTS match no entry and are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i <= N_INPUTS; i++)
            r_mem[i] <= FP_ZERO;
      end else if (i_we) begin
         for (int unsigned i = 0; i <= N_INPUTS; i++)
            if (i_waddr == AW'(i))
               r_mem[i] <= i_wdata;
      end
   end

   assign o_weight = r_mem[i_ridx];
   assign o_bias   = r_mem[N_INPUTS];

endmodule

// File: rtl/node_mac_seq.sv
// Time-multiplexed neuron node: one multiply-add per accepted activation,
// sequential summation ((b+x0w0)+x1w1)+..., result on an output handshake.
// NODE_MAC_SEQ_RELU_EN: when defined, the output is ReLU(acc); otherwise
// the accumulator passes through unchanged.
module node_mac_seq
   import node_pkg::*;
#(
   parameter int unsigned N_INPUTS = 15,
   parameter int unsigned AW       = $clog2(N_INPUTS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          w_we,
   input  logic [AW-1:0] w_addr,
   input  logic [31:0]   w_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_data,
   output logic          busy
);

   node_state_t     r_state, w_state_nxt;
   logic [AW-1:0]   r_cnt, w_cnt_nxt;
   logic [FP_W-1:0] r_acc, w_acc_nxt;
   logic [FP_W-1:0] w_weight, w_bias, w_prod, w_addend, w_sum;
   logic            w_rf_we;

   assign w_rf_we = w_we && (r_state == S_IDLE);

   node_weight_rf #(
      .N_INPUTS (N_INPUTS),
      .AW       (AW)
   ) u_rf (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_rf_we),
      .i_waddr  (w_addr),
      .i_wdata  (w_data),
      .i_ridx   (r_cnt),
      .o_weight (w_weight),
      .o_bias   (w_bias)
   );

   // The first element adds onto the bias, later ones onto the accumulator.
   assign w_addend = (r_state == S_IDLE) ? w_bias : r_acc;

   float_mult u_mult (
      .A   (in_data),
      .B   (w_weight),
      .Out (w_prod)
   );

   float_adder u_add (
      .A        (w_addend),
      .B        (w_prod),
      .Out      (w_sum),
      .Out_test (),
      .shift    (),
      .c_out    ()
   );

   // State, element counter and accumulator registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_acc   <= FP_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_acc   <= w_acc_nxt;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_acc_nxt   = r_acc;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_acc_nxt   = w_sum;
               w_cnt_nxt   = AW'(1);
               w_state_nxt = (N_INPUTS == 1) ? S_OUT : S_ACCUM;
            end
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               w_acc_nxt = w_sum;
               w_cnt_nxt = r_cnt + AW'(1);
               if (r_cnt == AW'(N_INPUTS - 1))
                  w_state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (rst) in_ready = 1'b0;
   end

`ifdef NODE_MAC_SEQ_RELU_EN
   assign out_data = r_acc[31] ? FP_ZERO : r_acc;
`else
   assign out_data = r_acc;
`endif

endmodule

// File: tb/tb_node_mac_seq.sv
// Directed and randomized checks of node_mac_seq (N_INPUTS=4 and 1) against
// a real-arithmetic reference model.
module tb_node_mac_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // N_INPUTS = 4 instance
   logic        rst, w_we, in_valid, out_ready;
   logic [2:0]  w_addr;
   logic [31:0] w_data, in_data;
   logic        in_ready, out_valid, busy;
   logic [31:0] out_data;

   // N_INPUTS = 1 instance
   logic        rst1, w_we1, in_valid1, out_ready1;
   logic [0:0]  w_addr1;
   logic [31:0] w_data1, in_data1;
   logic        in_ready1, out_valid1, busy1;
   logic [31:0] out_data1;

   node_mac_seq #(.N_INPUTS(4)) u_dut4 (
      .clk(clk), .rst(rst), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   node_mac_seq #(.N_INPUTS(1)) u_dut1 (
      .clk(clk), .rst(rst1), .w_we(w_we1), .w_addr(w_addr1), .w_data(w_data1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .busy(busy1)
   );

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] F_ONE  = 32'h3F80_0000;
   localparam logic [31:0] F_MONE = 32'hBF80_0000;
   localparam logic [31:0] F_HALF = 32'h3F00_0000;
   localparam logic [31:0] F_TWO  = 32'h4000_0000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Exact conversion of a real with a short mantissa to FP32 bits.
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] b;
      int          e;
      if (r == 0.0) return 32'h0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 896;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   // Random nonzero multiple of 0.25 in [-16, 16].
   function automatic real rnd_val();
      int k;
      k = int'($urandom_range(1, 64));
      if ($urandom_range(0, 1) == 1) k = -k;
      return real'(k) / 4.0;
   endfunction

   function automatic logic [31:0] act(input real r);
`ifdef NODE_MAC_SEQ_RELU_EN
      if (r < 0.0) return 32'h0;
`endif
      return r2f(r);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      w_we = 1'b1; w_addr = a; w_data = d;
      step();
      w_we = 1'b0;
   endtask

   // Idle `gap` cycles (optionally with writes that must be dropped), then
   // present one element for exactly one cycle.
   task automatic push(input logic [31:0] x, input int gap, input bit junk_wr);
      repeat (gap) begin
         if (junk_wr) begin
            w_we = 1'b1; w_addr = 3'($urandom_range(0, 4)); w_data = $urandom();
         end
         step();
         w_we = 1'b0;
      end
      chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = x;
      step();
      in_valid = 1'b0; in_data = $urandom();
   endtask

   // Called right after the last accept: result must already be valid.
   task automatic collect(input string tag, input logic [31:0] exp, input int hold);
      int waited = 0;
      while (out_valid !== 1'b1 && waited < 20) begin
         step();
         waited++;
      end
      chk({tag, "_latency"}, waited, 0);
      chk({tag, "_data"}, out_data, exp);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_in_ready_out"}, {31'd0, in_ready}, 32'd0);
      repeat (hold) begin
         step();
         chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         chk({tag, "_hold_data"}, out_data, exp);
         chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_post_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_post_in_ready"}, {31'd0, in_ready}, 32'd1);
   endtask

   task automatic load(input logic [31:0] w0, input logic [31:0] w, input logic [31:0] b);
      wr(3'd0, w0);
      for (int i = 1; i < 4; i++) wr(3'(i), w);
      wr(3'd4, b);
   endtask

   real         wv [4];
   real         bias, acc, x;
   logic [31:0] exp_v;

   initial begin
      rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      rst1 = 1'b1; w_we1 = 1'b0; w_addr1 = '0; w_data1 = '0;
      in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b0;

      // Reset state
      step();
      chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_out_data", out_data, 32'h0);
      step();
      rst = 1'b0; rst1 = 1'b0;
      step();
      chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back: 0.5 + 4 * (2.0 * 1.0) = 8.5
      load(F_ONE, F_ONE, F_HALF);
      for (int i = 0; i < 4; i++) push(F_TWO, 0, 1'b0);
      collect("b2b", 32'h4108_0000, 0);

      // Negative weights: -4.0, or 0 after ReLU
      load(F_MONE, F_MONE, 32'h0);
      for (int i = 0; i < 4; i++) push(F_ONE, 0, 1'b0);
`ifdef NODE_MAC_SEQ_RELU_EN
      collect("neg", 32'h0000_0000, 1);
`else
      collect("neg", 32'hC080_0000, 1);
`endif

      // Gaps of 2 between elements, consumer stalls 3 cycles
      load(F_ONE, F_ONE, F_HALF);
      push(F_TWO, 0, 1'b0);
      for (int i = 1; i < 4; i++) push(F_TWO, 2, 1'b0);
      collect("gaps", 32'h4108_0000, 3);

      // Write during ACCUM is dropped
      push(F_TWO, 0, 1'b0);
      push(F_TWO, 0, 1'b0);
      wr(3'd0, F_TWO);
      push(F_TWO, 0, 1'b0);
      push(F_TWO, 0, 1'b0);
      collect("accum_wr_dropped", 32'h4108_0000, 0);

      // Same write in IDLE lands: 0.5 + 4 + 2 + 2 + 2 = 10.5
      wr(3'd0, F_TWO);
      for (int i = 0; i < 4; i++) push(F_TWO, 0, 1'b0);
      collect("idle_wr", 32'h4128_0000, 0);

      // Out-of-range address (5) is ignored
      wr(3'd5, F_TWO);
      for (int i = 0; i < 4; i++) push(F_TWO, 0, 1'b0);
      collect("oob_wr", 32'h4128_0000, 0);

      // Write + accept in one IDLE cycle: element sees old w0 (2.0)
      w_we = 1'b1; w_addr = 3'd0; w_data = F_ONE;
      in_valid = 1'b1; in_data = F_TWO;
      step();
      w_we = 1'b0; in_valid = 1'b0;
      for (int i = 1; i < 4; i++) push(F_TWO, 0, 1'b0);
      collect("wr_and_accept_old", 32'h4128_0000, 0);
      for (int i = 0; i < 4; i++) push(F_TWO, 0, 1'b0);
      collect("wr_and_accept_landed", 32'h4108_0000, 0);

      // Reset mid-accumulation clears partial sum and weights
      push(F_TWO, 0, 1'b0);
      push(F_TWO, 0, 1'b0);
      rst = 1'b1;
      step();
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      step();
      for (int i = 0; i < 4; i++) push(F_TWO, 0, 1'b0);
      collect("after_rst", 32'h0000_0000, 0);

      // Randomized transactions vs. sequential real-arithmetic model
      for (int t = 0; t < 10; t++) begin
         bias = rnd_val();
         wr(3'd4, r2f(bias));
         for (int i = 0; i < 4; i++) begin
            wv[i] = rnd_val();
            wr(3'(i), r2f(wv[i]));
         end
         acc = bias;
         for (int i = 0; i < 4; i++) begin
            x   = rnd_val();
            acc = acc + x * wv[i];
            push(r2f(x), (i == 0) ? 0 : int'($urandom_range(0, 2)), i != 0);
         end
         exp_v = act(acc);
         collect("rand", exp_v, int'($urandom_range(0, 2)));
      end

      // N_INPUTS = 1: 3.0 * 2.0 - 1.0 = 5.0, straight IDLE -> OUT
      for (int r = 0; r < 2; r++) begin
         w_we1 = 1'b1; w_addr1 = 1'b0; w_data1 = 32'h4040_0000;
         step();
         w_addr1 = 1'b1; w_data1 = F_MONE;
         step();
         w_we1 = 1'b0;
         chk("n1_in_ready", {31'd0, in_ready1}, 32'd1);
         in_valid1 = 1'b1; in_data1 = F_TWO;
         step();
         in_valid1 = 1'b0;
         chk("n1_out_valid", {31'd0, out_valid1}, 32'd1);
         chk("n1_in_ready_out", {31'd0, in_ready1}, 32'd0);
         chk("n1_busy", {31'd0, busy1}, 32'd1);
         chk("n1_data", out_data1, 32'h40A0_0000);
         out_ready1 = 1'b1;
         step();
         out_ready1 = 1'b0;
         chk("n1_post_valid", {31'd0, out_valid1}, 32'd0);
         chk("n1_post_busy", {31'd0, busy1}, 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
